ym_write_seq: RTL and testbench
===============================

Name: ym_write_seq

Overview:
- Z80-side bus initiator that turns queued YM2610 register-write requests (part, register, value) into the chip's two-step write protocol: an address strobe, then a data strobe.
- Drives the nWRITE_S / ADDR_S / DATA_S port of the YM register file and honours its BUSY_MMR flag.
- Buffers requests in a small FIFO.
- Optionally skips the address strobe when the target already holds the same part and address.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 2, idle cycles enforced after each strobe is released before the next strobe may be issued; range 0–15.
- SKIP_EN, 1, 1 = suppress the address strobe when the cached part/address match the request.

Ports:
- PHI_M  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  FIFO can accept; equals !full && !RESET
- REQ_PART  in  1  0 = part A, 1 = part B
- REQ_ADDR  in  8  register address
- REQ_DATA  in  8  register value
- INVALIDATE  in  1  clears the address cache (for example after another master has written)
- BUSY_MMR  in  1  busy flag from the register file
- nWRITE_S  out  1  write strobe, active low, registered
- ADDR_S  out  2  bit0 = 0 for address, 1 for data; bit1 = part; registered
- DATA_S  out  8  address or data byte, registered
- DONE  out  1  one-cycle pulse per completed request
- LEVEL  out  log2(DEPTH)+1  FIFO occupancy
- IDLE  out  1  high when the FIFO is empty and the FSM is in S_IDLE

Behaviour:
- Reset (synchronous, active-high):
  - nWRITE_S=1, ADDR_S=0, DATA_S=0, DONE=0, LEVEL=0, IDLE=1.
  - FIFO emptied; cache invalid; FSM to S_IDLE.
  - A strobe in progress is released at the reset edge.
- FIFO:
  - Push when REQ_VALID && REQ_READY; pop only in S_IDLE.
  - No push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave LEVEL unchanged.
  - Pointers wrap modulo DEPTH.
- Strobe rule:
  - nWRITE_S is low for exactly one cycle per strobe. The target re-triggers if the strobe is held low.
  - A strobe is asserted only on an edge where the sampled BUSY_MMR is 0.
- FSM states: S_IDLE, S_ADDR, S_DATA, S_HOLD, S_GAP.
- S_IDLE:
  - If the FIFO is non-empty, pop the entry into holding registers (P, A, D).
  - If SKIP_EN && cache valid && cache == {P, A}, go to S_DATA; otherwise go to S_ADDR.
- S_ADDR:
  - When BUSY_MMR=0: nWRITE_S<=0, ADDR_S<={P,0}, DATA_S<=A.
  - Cache<={P, A}, cache valid; phase flag = address; go to S_HOLD.
- S_DATA:
  - When BUSY_MMR=0: nWRITE_S<=0, ADDR_S<={P,1}, DATA_S<=D.
  - Phase flag = data; go to S_HOLD.
- S_HOLD:
  - nWRITE_S<=1; ADDR_S and DATA_S hold their values.
  - Gap counter <= GAP_CYCLES.
  - If phase = data, DONE<=1 for one cycle.
  - Go to S_GAP.
- S_GAP:
  - Decrement the counter while it is non-zero.
  - When the counter is 0: go to S_DATA if phase = address, else S_IDLE.
  - With GAP_CYCLES=0 the FSM passes through S_GAP in one cycle.
- Resulting spacing between strobe-assert edges is at least GAP_CYCLES+3 edges, stretched by any BUSY_MMR=1.
- Latency from an empty FIFO, push at edge 0, GAP_CYCLES=2, BUSY low throughout:
  - pop at edge 1;
  - address strobe asserted at edge 2, released at edge 3;
  - data strobe asserted at edge 7, released at edge 8;
  - DONE high during cycle 8→9;
  - back in S_IDLE at edge 11.
- Skip path: the data strobe is asserted at edge 2.
- INVALIDATE:
  - Clears cache valid on that edge.
  - If INVALIDATE coincides with the S_ADDR strobe edge, the strobe's cache write wins.
  - Does not affect a request already in flight.
- Part switch: a request with a different part always forces an address strobe, because the target rejects data writes whose part mismatches its latched part.

Test Plan:
- Reset, then push {P=0, A=0x27, D=0x15}, BUSY=0 -> address strobe at edge 2 with ADDR_S=00, DATA_S=0x27; data strobe at edge 7 with ADDR_S=01, DATA_S=0x15; one DONE pulse; nWRITE_S low exactly 2 cycles total.
- Push {0,0x24,0x11} then {0,0x24,0x22} with SKIP_EN=1 -> the second request issues only a data strobe (DATA_S=0x22); 3 strobes total, 2 DONE pulses.
- Push {0,0x10,0x80} then {1,0x10,0x01} -> the second request re-issues an address strobe with ADDR_S=10, DATA_S=0x10, then data with ADDR_S=11.
- Hold BUSY_MMR=1 for 5 cycles at the address-strobe point -> no strobe while busy; the strobe occurs on the first edge with BUSY=0; DATA_S unchanged.
- Push 9 requests back to back with DEPTH=8 while BUSY=1 -> REQ_READY falls at LEVEL=8; the 9th is accepted only after a pop; all 9 complete in order.
- Assert RESET one cycle after an address strobe, with 3 entries queued -> nWRITE_S=1, LEVEL=0, no DONE; the next request after reset performs an address strobe even if it matches the previous address.

Source files
------------

// File: rtl/ym_write_seq.sv
// ym_write_seq
//   Z80-side bus initiator for the YM2610 register file. Queued write
//   requests (part, register, value) are turned into the chip's two-step
//   write: an address strobe followed by a data strobe. The address strobe
//   is skipped when the target already holds the same part/address.
//
// Ports
//   PHI_M       clock
//   RESET       synchronous, active-high reset
//   REQ_VALID   request present
//   REQ_READY   request accepted this cycle (FIFO not full, not in reset)
//   REQ_PART    0 = part A, 1 = part B
//   REQ_ADDR    register address
//   REQ_DATA    register value
//   INVALIDATE  forget the cached part/address
//   BUSY_MMR    busy flag from the register file; no strobe while high
//   nWRITE_S    write strobe, active low, one cycle per strobe
//   ADDR_S      bit0 = 0 address / 1 data, bit1 = part
//   DATA_S      address or data byte
//   DONE        one-cycle pulse per completed request
//   LEVEL       FIFO occupancy
//   IDLE        FIFO empty and sequencer idle

module ym_write_seq #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int SKIP_EN    = 1
) (
    input  logic                     PHI_M,
    input  logic                     RESET,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic                     REQ_PART,
    input  logic [7:0]               REQ_ADDR,
    input  logic [7:0]               REQ_DATA,
    input  logic                     INVALIDATE,
    input  logic                     BUSY_MMR,
    output logic                     nWRITE_S,
    output logic [1:0]               ADDR_S,
    output logic [7:0]               DATA_S,
    output logic                     DONE,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     IDLE
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_GAP
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Request FIFO: entry = {part, addr, data}
    // ------------------------------------------------------------------
    logic [16:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [16:0]   head;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign REQ_READY = !full && !RESET;
    assign push      = REQ_VALID && REQ_READY;
    assign pop       = (state == S_IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr];
    assign LEVEL     = count;
    assign IDLE      = empty && (state == S_IDLE);

    always_ff @(posedge PHI_M) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {REQ_PART, REQ_ADDR, REQ_DATA};
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge PHI_M) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    logic       p_q;
    logic [7:0] a_q;
    logic [7:0] d_q;
    logic [8:0] cache_tag;
    logic       cache_valid;
    logic       phase_data;
    logic [3:0] gap_cnt;
    logic       skip_ok;

    // An INVALIDATE arriving on the pop edge also blocks the skip, so the
    // request that follows it always re-establishes the address.
    assign skip_ok = (SKIP_EN != 0) && cache_valid && !INVALIDATE &&
                     (cache_tag == head[16:8]);

    always_ff @(posedge PHI_M) begin
        if (RESET) begin
            state       <= S_IDLE;
            nWRITE_S    <= 1'b1;
            ADDR_S      <= '0;
            DATA_S      <= '0;
            DONE        <= 1'b0;
            p_q         <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
            phase_data  <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            DONE <= 1'b0;

            // Placed before the case so the strobe's cache write wins.
            if (INVALIDATE) begin
                cache_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        {p_q, a_q, d_q} <= head;
                        state <= skip_ok ? S_DATA : S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (!BUSY_MMR) begin
                        nWRITE_S    <= 1'b0;
                        ADDR_S      <= {p_q, 1'b0};
                        DATA_S      <= a_q;
                        cache_tag   <= {p_q, a_q};
                        cache_valid <= 1'b1;
                        phase_data  <= 1'b0;
                        state       <= S_HOLD;
                    end
                end

                S_DATA: begin
                    if (!BUSY_MMR) begin
                        nWRITE_S   <= 1'b0;
                        ADDR_S     <= {p_q, 1'b1};
                        DATA_S     <= d_q;
                        phase_data <= 1'b1;
                        state      <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // Release after one cycle: the target re-triggers on a
                    // strobe held low.
                    nWRITE_S <= 1'b1;
                    gap_cnt  <= 4'(GAP_CYCLES);
                    if (phase_data) begin
                        DONE <= 1'b1;
                    end
                    state <= S_GAP;
                end

                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        state <= phase_data ? S_IDLE : S_DATA;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ym_write_seq.sv
module tb_ym_write_seq;

    logic       PHI_M;
    logic       RESET;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_PART;
    logic [7:0] REQ_ADDR;
    logic [7:0] REQ_DATA;
    logic       INVALIDATE;
    logic       BUSY_MMR;
    logic       nWRITE_S;
    logic [1:0] ADDR_S;
    logic [7:0] DATA_S;
    logic       DONE;
    logic [3:0] LEVEL;
    logic       IDLE;

    int checks = 0;
    int errors = 0;

    ym_write_seq #(
        .DEPTH      (8),
        .GAP_CYCLES (2),
        .SKIP_EN    (1)
    ) dut (
        .PHI_M      (PHI_M),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_PART   (REQ_PART),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_DATA   (REQ_DATA),
        .INVALIDATE (INVALIDATE),
        .BUSY_MMR   (BUSY_MMR),
        .nWRITE_S   (nWRITE_S),
        .ADDR_S     (ADDR_S),
        .DATA_S     (DATA_S),
        .DONE       (DONE),
        .LEVEL      (LEVEL),
        .IDLE       (IDLE)
    );

    initial PHI_M = 1'b0;
    always #5 PHI_M = ~PHI_M;

    // Strobe/DONE recorder, sampled 1 time unit after each rising edge.
    int         cyc = 0;
    int         low_cycles = 0;
    int         run_len = 0;
    int         max_run = 0;
    int         done_cnt = 0;
    int         done_edge = 0;
    logic       prev_nw = 1'b1;
    int         s_edge[$];
    logic [1:0] s_as[$];
    logic [7:0] s_ds[$];

    initial begin
        forever begin
            @(posedge PHI_M);
            cyc++;
            #1;
            if (nWRITE_S === 1'b0) begin
                low_cycles++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (prev_nw === 1'b1) begin
                    s_edge.push_back(cyc);
                    s_as.push_back(ADDR_S);
                    s_ds.push_back(DATA_S);
                end
            end else begin
                run_len = 0;
            end
            if (DONE === 1'b1) begin
                done_cnt++;
                done_edge = cyc;
            end
            prev_nw = nWRITE_S;
        end
    end

    task automatic clear_mon();
        s_edge.delete();
        s_as.delete();
        s_ds.delete();
        low_cycles = 0;
        max_run    = 0;
        done_cnt   = 0;
        done_edge  = 0;
    endtask

    // Present a request and hold it until accepted; returns the accepting edge.
    task automatic push_req(input logic p, input logic [7:0] a, input logic [7:0] d,
                            output int edge_no);
        logic ok;
        ok = 1'b0;
        REQ_PART  = p;
        REQ_ADDR  = a;
        REQ_DATA  = d;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ok = REQ_READY;
            @(posedge PHI_M);
            #2;
            if (ok) break;
        end
        REQ_VALID = 1'b0;
        edge_no = cyc;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout: accepted=%0b required=1", ok);
        end
    endtask

    task automatic wait_idle(input int maxc, output int idle_edge);
        logic seen;
        seen = 1'b0;
        idle_edge = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge PHI_M);
            #2;
            if (IDLE === 1'b1) begin
                seen = 1'b1;
                idle_edge = cyc;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL idle_timeout: IDLE=%0b required=1", IDLE);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge PHI_M);
        #2;
        checks++; if (nWRITE_S !== 1'b1) begin errors++; $display("FAIL rst_nwrite: got %0b want 1", nWRITE_S); end
        checks++; if (ADDR_S !== 2'b00) begin errors++; $display("FAIL rst_addr_s: got %0b want 00", ADDR_S); end
        checks++; if (DATA_S !== 8'h00) begin errors++; $display("FAIL rst_data_s: got %0h want 00", DATA_S); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", DONE); end
        checks++; if (LEVEL !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", LEVEL); end
        checks++; if (IDLE !== 1'b1) begin errors++; $display("FAIL rst_idle: got %0b want 1", IDLE); end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", REQ_READY); end
        RESET = 1'b0;
        #1;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", REQ_READY); end
    endtask

    task automatic test_single();
        int e0, ie;
        clear_mon();
        push_req(1'b0, 8'h27, 8'h15, e0);
        checks++; if (LEVEL !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", LEVEL); end
        wait_idle(60, ie);
        checks++; if (s_edge.size() !== 2) begin errors++; $display("FAIL single_nstrobe: got %0d want 2", s_edge.size()); end
        checks++; if (s_edge[0] !== e0 + 2) begin errors++; $display("FAIL single_a_edge: got %0d want %0d", s_edge[0], e0 + 2); end
        checks++; if (s_as[0] !== 2'b00) begin errors++; $display("FAIL single_a_as: got %0b want 00", s_as[0]); end
        checks++; if (s_ds[0] !== 8'h27) begin errors++; $display("FAIL single_a_ds: got %0h want 27", s_ds[0]); end
        checks++; if (s_edge[1] !== e0 + 7) begin errors++; $display("FAIL single_d_edge: got %0d want %0d", s_edge[1], e0 + 7); end
        checks++; if (s_as[1] !== 2'b01) begin errors++; $display("FAIL single_d_as: got %0b want 01", s_as[1]); end
        checks++; if (s_ds[1] !== 8'h15) begin errors++; $display("FAIL single_d_ds: got %0h want 15", s_ds[1]); end
        checks++; if (low_cycles !== 2) begin errors++; $display("FAIL single_low: got %0d want 2", low_cycles); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
        checks++; if (done_edge !== e0 + 8) begin errors++; $display("FAIL single_done_edge: got %0d want %0d", done_edge, e0 + 8); end
        checks++; if (ie !== e0 + 11) begin errors++; $display("FAIL single_idle_edge: got %0d want %0d", ie, e0 + 11); end
    endtask

    task automatic test_skip();
        int e0, e1, ie;
        clear_mon();
        push_req(1'b0, 8'h24, 8'h11, e0);
        push_req(1'b0, 8'h24, 8'h22, e1);
        wait_idle(80, ie);
        checks++; if (s_edge.size() !== 3) begin errors++; $display("FAIL skip_nstrobe: got %0d want 3", s_edge.size()); end
        checks++; if (s_ds[0] !== 8'h24) begin errors++; $display("FAIL skip_first_addr: got %0h want 24", s_ds[0]); end
        checks++; if (s_as[2] !== 2'b01) begin errors++; $display("FAIL skip_as: got %0b want 01", s_as[2]); end
        checks++; if (s_ds[2] !== 8'h22) begin errors++; $display("FAIL skip_ds: got %0h want 22", s_ds[2]); end
        checks++; if (s_edge[2] !== e0 + 13) begin errors++; $display("FAIL skip_edge: got %0d want %0d", s_edge[2], e0 + 13); end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL skip_done: got %0d want 2", done_cnt); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL skip_low_run: got %0d want 1", max_run); end
    endtask

    task automatic test_part_switch();
        int e0, e1, ie;
        clear_mon();
        push_req(1'b0, 8'h10, 8'h80, e0);
        push_req(1'b1, 8'h10, 8'h01, e1);
        wait_idle(80, ie);
        checks++; if (s_edge.size() !== 4) begin errors++; $display("FAIL part_nstrobe: got %0d want 4", s_edge.size()); end
        checks++; if (s_as[1] !== 2'b01 || s_ds[1] !== 8'h80) begin errors++; $display("FAIL part_d0: got %0b/%0h want 01/80", s_as[1], s_ds[1]); end
        checks++; if (s_as[2] !== 2'b10 || s_ds[2] !== 8'h10) begin errors++; $display("FAIL part_a1: got %0b/%0h want 10/10", s_as[2], s_ds[2]); end
        checks++; if (s_as[3] !== 2'b11 || s_ds[3] !== 8'h01) begin errors++; $display("FAIL part_d1: got %0b/%0h want 11/01", s_as[3], s_ds[3]); end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL part_done: got %0d want 2", done_cnt); end
    endtask

    task automatic test_busy();
        int e0, ie;
        clear_mon();
        push_req(1'b0, 8'h33, 8'h44, e0);
        @(posedge PHI_M);
        #2;
        BUSY_MMR = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge PHI_M);
            #2;
            checks++;
            if (nWRITE_S !== 1'b1 || DATA_S !== 8'h01) begin
                errors++;
                $display("FAIL busy_hold[%0d]: got nW=%0b ds=%0h want nW=1 ds=01", i, nWRITE_S, DATA_S);
            end
        end
        BUSY_MMR = 1'b0;
        wait_idle(60, ie);
        checks++; if (s_edge[0] !== e0 + 7 || s_ds[0] !== 8'h33) begin errors++; $display("FAIL busy_addr: got edge %0d ds %0h want edge %0d ds 33", s_edge[0], s_ds[0], e0 + 7); end
        checks++; if (s_edge[1] !== e0 + 12 || s_ds[1] !== 8'h44) begin errors++; $display("FAIL busy_data: got edge %0d ds %0h want edge %0d ds 44", s_edge[1], s_ds[1], e0 + 12); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
    endtask

    // One request is held in flight by BUSY, the next eight fill the FIFO,
    // and the following one must wait for a pop.
    task automatic test_full();
        int e, ie;
        logic [7:0] a;
        logic [7:0] d;
        clear_mon();
        BUSY_MMR = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = 8'h40 + 8'(i);
            d = 8'h90 + 8'(i);
            push_req(1'b0, a, d, e);
        end
        checks++; if (LEVEL !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", LEVEL); end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", REQ_READY); end
        REQ_PART  = 1'b0;
        REQ_ADDR  = 8'h49;
        REQ_DATA  = 8'h99;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge PHI_M);
            #2;
            checks++;
            if (LEVEL !== 4'd8 || REQ_READY !== 1'b0) begin
                errors++;
                $display("FAIL full_block[%0d]: got level %0d ready %0b want 8/0", i, LEVEL, REQ_READY);
            end
        end
        checks++; if (s_edge.size() !== 0) begin errors++; $display("FAIL full_busy_strobe: got %0d want 0", s_edge.size()); end
        BUSY_MMR = 1'b0;
        push_req(1'b0, 8'h49, 8'h99, e);
        wait_idle(400, ie);
        checks++; if (s_edge.size() !== 20) begin errors++; $display("FAIL full_nstrobe: got %0d want 20", s_edge.size()); end
        for (int i = 0; i < 10; i++) begin
            a = 8'h40 + 8'(i);
            d = 8'h90 + 8'(i);
            checks++;
            if (s_ds[2*i] !== a || s_ds[2*i+1] !== d || s_as[2*i+1] !== 2'b01) begin
                errors++;
                $display("FAIL full_order[%0d]: got %0h/%0h as %0b want %0h/%0h as 01", i, s_ds[2*i], s_ds[2*i+1], s_as[2*i+1], a, d);
            end
        end
        checks++; if (done_cnt !== 10) begin errors++; $display("FAIL full_done: got %0d want 10", done_cnt); end
    endtask

    task automatic test_reset_midflight();
        int e, ie;
        clear_mon();
        BUSY_MMR = 1'b1;
        push_req(1'b0, 8'h50, 8'h01, e);
        push_req(1'b0, 8'h51, 8'h02, e);
        push_req(1'b0, 8'h52, 8'h03, e);
        push_req(1'b0, 8'h53, 8'h04, e);
        checks++; if (LEVEL !== 4'd3) begin errors++; $display("FAIL mid_level: got %0d want 3", LEVEL); end
        BUSY_MMR = 1'b0;
        @(posedge PHI_M);
        #2;
        checks++; if (nWRITE_S !== 1'b0 || DATA_S !== 8'h50) begin errors++; $display("FAIL mid_strobe: got nW=%0b ds=%0h want 0/50", nWRITE_S, DATA_S); end
        RESET = 1'b1;
        @(posedge PHI_M);
        #2;
        checks++; if (nWRITE_S !== 1'b1) begin errors++; $display("FAIL mid_rst_nwrite: got %0b want 1", nWRITE_S); end
        checks++; if (LEVEL !== 4'd0) begin errors++; $display("FAIL mid_rst_level: got %0d want 0", LEVEL); end
        checks++; if (IDLE !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %0b want 1", IDLE); end
        checks++; if (ADDR_S !== 2'b00 || DATA_S !== 8'h00) begin errors++; $display("FAIL mid_rst_bus: got %0b/%0h want 00/00", ADDR_S, DATA_S); end
        RESET = 1'b0;
        repeat (6) @(posedge PHI_M);
        #2;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        checks++; if (s_edge.size() !== 1) begin errors++; $display("FAIL mid_no_strobe: got %0d want 1", s_edge.size()); end
        clear_mon();
        push_req(1'b0, 8'h50, 8'h77, e);
        wait_idle(60, ie);
        checks++; if (s_edge.size() !== 2) begin errors++; $display("FAIL mid_after_nstrobe: got %0d want 2", s_edge.size()); end
        checks++; if (s_as[0] !== 2'b00 || s_ds[0] !== 8'h50) begin errors++; $display("FAIL mid_after_addr: got %0b/%0h want 00/50", s_as[0], s_ds[0]); end
        checks++; if (s_as[1] !== 2'b01 || s_ds[1] !== 8'h77) begin errors++; $display("FAIL mid_after_data: got %0b/%0h want 01/77", s_as[1], s_ds[1]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mid_after_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        RESET      = 1'b1;
        REQ_VALID  = 1'b0;
        REQ_PART   = 1'b0;
        REQ_ADDR   = 8'h00;
        REQ_DATA   = 8'h00;
        INVALIDATE = 1'b0;
        BUSY_MMR   = 1'b0;
        test_reset();
        test_single();
        test_skip();
        test_part_switch();
        test_busy();
        test_full();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
